// File: rtl/round_key_stream.sv
// round_key_stream: XORs each incoming state beat with a selected round key from a writable bank.
// Latency: one registered output stage, out_valid rises 1 cycle after accept; 1 beat/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; the held beat stays stable while out_ready is low.
// Optional build macro ROUND_KEY_AUTO_ROUND_EN: key select comes from an internal wrapping index
// instead of in_round.
module round_key_stream #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 15,
  localparam int IDX_W   = $clog2(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_idx,
  input  logic [DATA_W-1:0] key_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              err,
  input  logic              err_clr,
  output logic [31:0]       beat_cnt
);

  // Bank depth widened by one bit so NUM_KEYS itself is representable for range checks.
  localparam logic [IDX_W:0] NK    = (IDX_W+1)'(NUM_KEYS);
  localparam logic [IDX_W:0] NK_M1 = (IDX_W+1)'(NUM_KEYS - 1);

  logic [DATA_W-1:0] bank_q [NUM_KEYS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]  out_round_q, out_round_d;
  logic              err_q,       err_d;
  logic [31:0]       beat_cnt_q,  beat_cnt_d;

  logic              accept;
  logic [IDX_W-1:0]  sel;
  logic              sel_ok;
  logic              key_wr_ok;
  logic [DATA_W-1:0] key_sel;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign sel_ok    = ({1'b0, sel} < NK);
  assign key_wr_ok = ({1'b0, key_idx} < NK);
  // An out-of-range select passes the state through untouched.
  assign key_sel   = sel_ok ? bank_q[sel] : '0;

`ifdef ROUND_KEY_AUTO_ROUND_EN
  logic [IDX_W-1:0] auto_idx_q, auto_idx_d;
  logic             unused_in_round;

  assign unused_in_round = ^in_round;
  assign sel             = auto_idx_q;

  // Advance the auto index once per accepted beat, wrapping after the last key.
  always_comb begin
    auto_idx_d = auto_idx_q;
    if (accept) begin
      auto_idx_d = ({1'b0, auto_idx_q} == NK_M1) ? '0 : auto_idx_q + IDX_W'(1);
    end
  end

  // Auto index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_idx_q <= '0;
    end else begin
      auto_idx_q <= auto_idx_d;
    end
  end
`else
  logic unused_nk_m1;

  assign unused_nk_m1 = ^NK_M1;
  assign sel          = in_round;
`endif

  // Key bank: a same-cycle read by an accept sees the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (key_we && key_wr_ok) begin
      bank_q[key_idx] <= key_data;
    end
  end

  // Output stage next state: load on accept, otherwise drain on output transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ key_sel;
      out_round_d = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky error (set beats clear) and saturating accepted-beat counter.
  always_comb begin
    err_d = err_clr ? 1'b0 : err_q;
    if (accept && !sel_ok) begin
      err_d = 1'b1;
    end
    beat_cnt_d = beat_cnt_q;
    if (accept && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  // Output, error and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign err       = err_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_round_key_stream.sv
// Directed bench for round_key_stream: reset, keyed XOR, streaming, stall, bad index,
// read-before-write and asynchronous reset; auto-index sequencing when built with the macro.
module tb_round_key_stream;
`ifdef ROUND_KEY_AUTO_ROUND_EN
  localparam int NK = 4;
`else
  localparam int NK = 15;
`endif
  localparam int DW = 128;
  localparam int IW = $clog2(NK);

  localparam logic [DW-1:0] K1 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_we;
  logic [IW-1:0] key_idx;
  logic [DW-1:0] key_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_round;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_round;
  logic          err;
  logic          err_clr;
  logic [31:0]   beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  round_key_stream #(.DATA_W(DW), .NUM_KEYS(NK)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_round(out_round),
    .err(err), .err_clr(err_clr), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    key_we = 1'b0; key_idx = '0; key_data = '0;
    in_valid = 1'b0; in_data = '0; in_round = '0;
    out_ready = 1'b1; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_key(input int idx, input logic [DW-1:0] k);
    key_we = 1'b1; key_idx = IW'(idx); key_data = k;
    tick();
    key_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    in_valid = 1'b1;
    in_data  = '1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_round !== '0) begin n_err++; $display("FAIL reset_out_round: got %0d want 0", out_round); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", err); end
    n_cmp++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_held_valid: got %0b want 0", out_valid); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp;
    exp = 128'h00102030_40506070_8090A0B0_C0D0E0F0;
    write_key(0, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    in_valid = 1'b1; in_round = IW'(0); out_ready = 1'b0;
    in_data  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL basic_data: got %h want %h", out_data, exp); end
    n_cmp++; if (out_round !== IW'(0)) begin n_err++; $display("FAIL basic_round: got %0d want 0", out_round); end
    n_cmp++; if (beat_cnt !== 32'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", beat_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    do_reset();
    write_key(1, K1);
    out_ready = 1'b1; in_round = IW'(1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {4{32'(i + 1)}};
      exp      = {4{32'(i + 1)}} ^ K1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
        n_err++; $display("FAIL b2b_beat[%0d]: got v=%0b %h want v=1 %h", i, out_valid, out_data, exp);
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (beat_cnt !== 32'd20) begin n_err++; $display("FAIL b2b_cnt: got %0d want 20", beat_cnt); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = 128'h11111111_22222222_33333333_44444444;
    b = 128'h55555555_66666666_77777777_88888888;
    in_round = IW'(1); out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %0b want 0", c, in_ready); end
      n_cmp++; if (out_data !== (a ^ K1)) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", c, out_data, a ^ K1); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== (b ^ K1)) begin
      n_err++; $display("FAIL stall_next: got v=%0b %h want v=1 %h", out_valid, out_data, b ^ K1);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %0b want 0", out_valid); end
    n_cmp++; if (beat_cnt !== 32'd22) begin n_err++; $display("FAIL stall_cnt: got %0d want 22", beat_cnt); end
  endtask

  task automatic test_bad_index();
    logic [DW-1:0] x;
    x = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    out_ready = 1'b1;
    in_valid = 1'b1; in_round = IW'(15); in_data = x;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== x) begin n_err++; $display("FAIL bad_data: got %h want %h", out_data, x); end
    n_cmp++; if (out_round !== IW'(15)) begin n_err++; $display("FAIL bad_round: got %0d want 15", out_round); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL bad_err_set: got %0b want 1", err); end
    in_valid = 1'b1; in_round = IW'(1); err_clr = 1'b1;
    tick();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_clr_good: got %0b want 0", err); end
    err_clr = 1'b0; in_round = IW'(15);
    tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL bad_reset_err: got %0b want 1", err); end
    err_clr = 1'b1;
    tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL bad_set_wins: got %0b want 1", err); end
    in_valid = 1'b0;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_clr_idle: got %0b want 0", err); end
    write_key(15, '1);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_key_write_err: got %0b want 0", err); end
    tick();
  endtask

  task automatic test_rbw();
    logic [DW-1:0] k_old;
    logic [DW-1:0] k_new;
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    k_old = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
    k_new = 128'hF0000000_0000000F_F0000000_0000000F;
    d     = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;
    d2    = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    write_key(3, k_old);
    out_ready = 1'b1;
    key_we = 1'b1; key_idx = IW'(3); key_data = k_new;
    in_valid = 1'b1; in_round = IW'(3); in_data = d;
    tick();
    key_we = 1'b0;
    n_cmp++; if (out_data !== (d ^ k_old)) begin n_err++; $display("FAIL rbw_old: got %h want %h", out_data, d ^ k_old); end
    in_data = d2;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== (d2 ^ k_new)) begin n_err++; $display("FAIL rbw_new: got %h want %h", out_data, d2 ^ k_new); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_round = IW'(0); in_data = 128'h1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_held: got %0b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rmid_data: got %h want 0", out_data); end
    n_cmp++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", beat_cnt); end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_auto();
    logic [DW-1:0] d;
    do_reset();
    out_ready = 1'b1; in_round = IW'(3);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      d = {4{32'(i + 16)}};
      in_data = d;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_round !== IW'(i % 4) || out_data !== d) begin
        n_err++; $display("FAIL auto_seq[%0d]: got v=%0b r=%0d %h want v=1 r=%0d %h", i, out_valid, out_round, out_data, i % 4, d);
      end
    end
    tick();
    n_cmp++; if (out_round !== IW'(2)) begin n_err++; $display("FAIL auto_seq[6]: got %0d want 2", out_round); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL auto_rst_valid: got %0b want 0", out_valid); end
    #2;
    rst_n = 1'b1;
    in_data = 128'h77;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_round !== IW'(0)) begin
      n_err++; $display("FAIL auto_after_rst: got v=%0b r=%0d want v=1 r=0", out_valid, out_round);
    end
    tick();
  endtask

  initial begin
    test_reset();
`ifdef ROUND_KEY_AUTO_ROUND_EN
    test_auto();
`else
    test_basic();
    test_back_to_back();
    test_stall();
    test_bad_index();
    test_rbw();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
